// File: rtl/digit_motion_pkg.sv
// Shared definitions for the moving-digit position generators: FSM state
// encoding and OLED panel geometry.
package digit_motion_pkg;

   localparam int unsigned OLED_WIDTH  = 96;
   localparam int unsigned OLED_HEIGHT = 64;

   // Coordinate width able to address any pixel on either panel axis
   localparam int unsigned OLED_COORD_W =
      $clog2((OLED_WIDTH > OLED_HEIGHT) ? OLED_WIDTH : OLED_HEIGHT);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HOLD     = 3'd1,
      MOVE_INC = 3'd2,
      MOVE_DEC = 3'd3,
      DWELL    = 3'd4
   } state_e;

endpackage

// File: rtl/digit_motion_tick_gen.sv
// Enable-gated prescaler: registered one-clk tick every DIV cycles while en is
// high; count and tick are held at zero while en is low.
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] count;

   // tick is registered one count early so it is high exactly while count==DIV-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (!en) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (count == CNT_W'(DIV - 2));
         count <= (count == CNT_W'(DIV - 1)) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/digit_motion_ctrl.sv
// Bouncing coordinate generator for one axis of a moving digit.
// Optional endpoint dwell is enabled by defining DIGIT_DWELL_EN.
module digit_motion_ctrl
   import digit_motion_pkg::*;
#(
   parameter int unsigned COORD_W     = OLED_COORD_W,
   parameter int unsigned TICK_DIV    = 4000000,
   parameter int unsigned STEP        = 1,
   parameter int unsigned DWELL_TICKS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               set,
   input  logic [COORD_W-1:0] lower_bound,
   input  logic [COORD_W-1:0] upper_bound,
   output logic [COORD_W-1:0] coord,
   output logic               dir_inc,
   output logic               edge_hit,
   output logic               busy
);

   localparam int unsigned SUM_W = COORD_W + 1;
   localparam logic [SUM_W-1:0] STEP_W = SUM_W'(STEP);

   if (TICK_DIV < 2 || STEP < 1 || DWELL_TICKS < 1) begin : g_param_check
      $error("digit_motion_ctrl: TICK_DIV>=2, STEP>=1, DWELL_TICKS>=1 required");
   end

`ifdef DIGIT_DWELL_EN
   localparam int unsigned DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam state_e AFTER_HI = DWELL;
   localparam state_e AFTER_LO = DWELL;
   logic [DWELL_W-1:0] dwell_cnt;
`else
   localparam state_e AFTER_HI = MOVE_DEC;
   localparam state_e AFTER_LO = MOVE_INC;
`endif

   state_e             state;
   logic               tick;
   logic [COORD_W-1:0] lo_q;
   logic [COORD_W-1:0] hi_q;
   logic [SUM_W-1:0]   inc_sum;
   logic [SUM_W-1:0]   dec_lim;

   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .tick  (tick)
   );

   // One extra bit so an overshoot past the top bound cannot wrap
   assign inc_sum = {1'b0, coord} + STEP_W;
   assign dec_lim = {1'b0, lo_q} + STEP_W;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         coord    <= '0;
         dir_inc  <= 1'b1;
         edge_hit <= 1'b0;
         busy     <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
`ifdef DIGIT_DWELL_EN
         dwell_cnt <= '0;
`endif
      end else begin
         edge_hit <= 1'b0;
         if (!set) begin
            // Parking beats any pending move, including one on this tick
            state   <= IDLE;
            coord   <= lower_bound;
            dir_inc <= 1'b1;
            busy    <= 1'b0;
`ifdef DIGIT_DWELL_EN
            dwell_cnt <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  coord   <= lower_bound;
                  dir_inc <= 1'b1;
                  lo_q    <= lower_bound;
                  hi_q    <= upper_bound;
                  if (lower_bound < upper_bound) begin
                     state <= MOVE_INC;
                     busy  <= 1'b1;
                  end else begin
                     state <= HOLD;
                     busy  <= 1'b0;
                  end
               end
               HOLD: begin
                  coord <= lo_q;
               end
               MOVE_INC: begin
                  if (tick) begin
                     if (inc_sum >= {1'b0, hi_q}) begin
                        coord    <= hi_q;
                        edge_hit <= 1'b1;
                        dir_inc  <= 1'b0;
                        state    <= AFTER_HI;
                     end else begin
                        coord <= inc_sum[COORD_W-1:0];
                     end
                  end
               end
               MOVE_DEC: begin
                  // Clamp when this step would land on or below the floor
                  if (tick) begin
                     if ({1'b0, coord} <= dec_lim) begin
                        coord    <= lo_q;
                        edge_hit <= 1'b1;
                        dir_inc  <= 1'b1;
                        state    <= AFTER_LO;
                     end else begin
                        coord <= coord - COORD_W'(STEP);
                     end
                  end
               end
`ifdef DIGIT_DWELL_EN
               DWELL: begin
                  // dir_inc already holds the reversed direction
                  if (tick) begin
                     if (dwell_cnt == DWELL_W'(DWELL_TICKS - 1)) begin
                        dwell_cnt <= '0;
                        state     <= dir_inc ? MOVE_INC : MOVE_DEC;
                     end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                     end
                  end
               end
`endif
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
